user_wb_fabric: RTL and testbench
=================================

Name: user_wb_fabric

Overview:
Parametrised Wishbone fabric between the management SoC slave port and NUM_SLAVES user-area peripherals. It is the next step beyond a single pass-through core wrapper.
- Decodes each upstream classic-cycle request against per-slave base/mask windows.
- Forwards the request to exactly one downstream port and returns its data.
- Answers unmapped addresses and hung slaves with an error word, so the SoC bus never stalls.
- Counts errors for debug via the logic-analyzer bank.

Parameters:
NUM_SLAVES, 4, number of downstream ports (1..8)
SLV_BASE, {32'h3000_3000,32'h3000_2000,32'h3000_1000,32'h3000_0000}, packed NUM_SLAVES*32 base addresses, slot k = bits [32k+31:32k]
SLV_MASK, {4{32'hFFFF_F000}}, packed NUM_SLAVES*32 decode masks
TIMEOUT_CYCLES, 255, max cycles waiting for a downstream ack; 0 disables timeout
ERR_DATA, 32'hDEAD_BEEF, read data returned on decode miss or timeout

Ports:
wb_clk_i  in  1  fabric clock (single clock domain)
wb_rst_n_i  in  1  synchronous, active-low reset
wbs_cyc_i / wbs_stb_i / wbs_we_i  in  1 each  upstream Wishbone control
wbs_sel_i  in  4  byte selects
wbs_adr_i / wbs_dat_i  in  32 each  address / write data
wbs_ack_o  out  1  upstream ack (one-cycle pulse)
wbs_dat_o  out  32  upstream read data (registered)
m_cyc_o / m_stb_o  out  NUM_SLAVES  one-hot downstream cycle/strobe
m_we_o  out  1  shared registered write enable
m_sel_o  out  4  shared registered byte selects
m_adr_o / m_dat_o  out  32 each  shared registered address / write data
m_dat_i  in  NUM_SLAVES*32  per-slave read data
m_ack_i  in  NUM_SLAVES  per-slave ack
err_cnt_o  out  16  saturating count of decode misses plus timeouts
busy_o  out  1  high while in state BUSY

Behaviour:
Reset (wb_rst_n_i low at a clock edge):
- FSM goes to IDLE.
- All outputs are 0; wbs_dat_o = 0; err_cnt_o = 0; timeout counter = 0.

Address decode:
- hit[k] = ((wbs_adr_i & SLV_MASK[k]) == SLV_BASE[k]).
- If several slots hit, the lowest k wins.

FSM states: IDLE, BUSY, RESP.
- IDLE: on wbs_cyc_i & wbs_stb_i, latch adr/dat/sel/we into the m_* registers.
  - On a hit, latch the one-hot sel and go to BUSY; m_cyc_o[k] and m_stb_o[k] rise on the same edge.
  - On a miss, load wbs_dat_o = ERR_DATA, increment err_cnt, go to RESP.
- BUSY: hold m_cyc_o[k]/m_stb_o[k] and increment the timeout counter each cycle.
  - If m_ack_i[k] is high: wbs_dat_o <= m_dat_i slice k (loaded on writes as well), drop cyc/stb, go to RESP.
  - Else if TIMEOUT_CYCLES != 0 and the counter equals TIMEOUT_CYCLES-1: wbs_dat_o <= ERR_DATA, err_cnt++, drop cyc/stb, go to RESP.
  - Ack and timeout in the same cycle: the ack wins and err_cnt is not incremented.
  - If wbs_cyc_i drops while in BUSY (upstream abort): drop cyc/stb and go to IDLE with no upstream ack.
- RESP: wbs_ack_o = 1 for exactly this one cycle, then IDLE.
  - A request is not accepted while in RESP. Back-to-back requests are accepted from IDLE on the following cycle.

Latency:
- Decode miss: ack in the 1st cycle after the request edge.
- Hit with a slave that acks in its first strobe cycle: ack in the 2nd cycle.
- Timeout: ack in cycle TIMEOUT_CYCLES+1.

Other rules:
- m_ack_i on a non-selected port, or outside BUSY, is ignored.
- err_cnt_o saturates at 16'hFFFF.
- The timeout counter is ceil(log2(TIMEOUT_CYCLES+1)) bits wide and clears on entering BUSY.
- Reset asserted mid-transaction aborts the transaction immediately: no ack, and all downstream strobes go low.

Decomposition:
Package user_wb_pkg:
- FSM state enum.
- Default ERR_DATA constant.
- Counter-width function.
- MAX_SLAVES = 8.

Sub-module user_wb_addr_decode:
- Combinational.
- Parameters NUM_SLAVES, SLV_BASE, SLV_MASK.
- Outputs a one-hot priority-resolved sel and a hit flag.

Test Plan:
1. Write 0x3000_1004 data 0x1234_5678 sel 0xF; slave1 acks on its 1st strobe cycle -> m_stb_o = 4'b0010, m_adr_o = 0x3000_1004, m_dat_o = 0x1234_5678; wbs_ack_o pulses 2 cycles after the request; err_cnt_o = 0.
2. Read 0x3000_3010; slave3 drives 0xCAFE_0003 and acks after 5 wait cycles -> wbs_dat_o = 0xCAFE_0003 with a single-cycle wbs_ack_o; busy_o high for 6 cycles.
3. Read unmapped 0x3100_0000 -> no m_stb_o activity; wbs_ack_o 1 cycle later with wbs_dat_o = 0xDEAD_BEEF; err_cnt_o = 1.
4. TIMEOUT_CYCLES = 8, slave0 never acks -> m_stb_o[0] high for exactly 8 cycles; then ack with 0xDEAD_BEEF; err_cnt_o increments. A second run with the ack arriving on the 8th cycle -> slave data returned, err_cnt_o unchanged.
5. Overlapping windows (SLV_BASE[0] = SLV_BASE[2]) -> only m_stb_o[0] asserts. A stray m_ack_i[2] during the transaction is ignored.
6. wbs_cyc_i dropped on the 3rd BUSY cycle, then wb_rst_n_i low mid-transaction -> strobes low next edge and no wbs_ack_o; after reset all outputs are 0 and err_cnt_o = 0.

Source files
------------

// File: rtl/user_wb_pkg.sv
// Shared types and constants for the user-area Wishbone fabric.
package user_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;
    localparam int          MAX_SLAVES       = 8;

    // Bits needed to count 0..cycles; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/user_wb_addr_decode.sv
// Base/mask window decoder: one-hot select with the lowest matching slot winning.
module user_wb_addr_decode
    import user_wb_pkg::*;
#(
    parameter int                       NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*32-1:0] SLV_BASE   = '0,
    parameter logic [NUM_SLAVES*32-1:0] SLV_MASK   = '0
) (
    input  logic [31:0]           adr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  hit
);

    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (!hit && ((adr & SLV_MASK[32*k +: 32]) == SLV_BASE[32*k +: 32])) begin
                sel[k] = 1'b1;
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/user_wb_fabric.sv
// Wishbone fabric: one upstream classic-cycle port fanned out to NUM_SLAVES windows,
// with error responses for unmapped addresses and hung slaves.
module user_wb_fabric
    import user_wb_pkg::*;
#(
    parameter int                       NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*32-1:0] SLV_BASE       = {32'h3000_3000, 32'h3000_2000,
                                                          32'h3000_1000, 32'h3000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SLV_MASK       = {4{32'hFFFF_F000}},
    parameter int                       TIMEOUT_CYCLES = 255,
    parameter logic [31:0]              ERR_DATA       = DEFAULT_ERR_DATA
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic [NUM_SLAVES-1:0]    m_cyc_o,
    output logic [NUM_SLAVES-1:0]    m_stb_o,
    output logic                     m_we_o,
    output logic [3:0]               m_sel_o,
    output logic [31:0]              m_adr_o,
    output logic [31:0]              m_dat_o,
    input  logic [NUM_SLAVES*32-1:0] m_dat_i,
    input  logic [NUM_SLAVES-1:0]    m_ack_i,
    output logic [15:0]              err_cnt_o,
    output logic                     busy_o
);

    localparam int            TW      = cnt_width(TIMEOUT_CYCLES);
    localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t                state, state_next;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_hit;
    logic [NUM_SLAVES-1:0] act_sel;
    logic [TW-1:0]         to_cnt;
    logic [15:0]           err_cnt;
    logic [31:0]           rdata;
    logic                  req;
    logic                  slave_ack;
    logic                  timed_out;
    logic                  latch_req;
    logic                  latch_sel;
    logic                  load_err;
    logic                  load_rdata;

    user_wb_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_decode (
        .adr (wbs_adr_i),
        .sel (dec_sel),
        .hit (dec_hit)
    );

    assign req       = wbs_cyc_i & wbs_stb_i;
    assign slave_ack = |(m_ack_i & act_sel);
    assign timed_out = TO_EN && (to_cnt == TO_LAST);

    // act_sel is non-zero only in BUSY, so it doubles as the read-data mux select.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            rdata = rdata | (m_dat_i[32*k +: 32] & {32{act_sel[k]}});
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        latch_req  = 1'b0;
        latch_sel  = 1'b0;
        load_err   = 1'b0;
        load_rdata = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    latch_req = 1'b1;
                    if (dec_hit) begin
                        latch_sel  = 1'b1;
                        state_next = BUSY;
                    end else begin
                        load_err   = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            BUSY: begin
                // An upstream abort outranks everything; an ack outranks the timeout.
                if (!wbs_cyc_i) begin
                    state_next = IDLE;
                end else if (slave_ack) begin
                    load_rdata = 1'b1;
                    state_next = RESP;
                end else if (timed_out) begin
                    load_err   = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            act_sel   <= '0;
            to_cnt    <= '0;
            err_cnt   <= '0;
            wbs_dat_o <= '0;
            m_we_o    <= 1'b0;
            m_sel_o   <= '0;
            m_adr_o   <= '0;
            m_dat_o   <= '0;
        end else begin
            if (latch_req) begin
                m_we_o  <= wbs_we_i;
                m_sel_o <= wbs_sel_i;
                m_adr_o <= wbs_adr_i;
                m_dat_o <= wbs_dat_i;
            end
            if (latch_sel) begin
                act_sel <= dec_sel;
            end else if (state_next != BUSY) begin
                act_sel <= '0;
            end
            if (latch_sel) begin
                to_cnt <= '0;
            end else if (state == BUSY) begin
                to_cnt <= to_cnt + TW'(1);
            end
            if (load_err) begin
                wbs_dat_o <= ERR_DATA;
            end else if (load_rdata) begin
                wbs_dat_o <= rdata;
            end
            if (load_err && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

    assign m_cyc_o   = act_sel;
    assign m_stb_o   = act_sel;
    assign wbs_ack_o = (state == RESP);
    assign busy_o    = (state == BUSY);
    assign err_cnt_o = err_cnt;

endmodule

// File: tb/tb_user_wb_fabric.sv
// Randomised and directed bench for user_wb_fabric against a transaction-level model
// (window lookup, latency and error-count rules), with overlapping slots 0/2 and an 8-cycle timeout.
module tb_user_wb_fabric;

    localparam int          NS      = 4;
    localparam int          TO      = 8;
    localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wbs_cyc = 1'b0, wbs_stb = 1'b0, wbs_we = 1'b0;
    logic [3:0]  wbs_sel = '0;
    logic [31:0] wbs_adr = '0, wbs_dat = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [3:0]  m_cyc_o, m_stb_o, m_ack_i;
    logic        m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_adr_o, m_dat_o;
    logic [127:0] m_dat_i;
    logic [15:0] err_cnt_o;
    logic        busy_o;

    logic [31:0] slvData [NS];
    logic [31:0] baseTab [NS] = '{32'h3000_0000, 32'h3000_1000, 32'h3000_0000, 32'h3000_3000};
    logic [31:0] maskTab [NS] = '{32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};
    int          checks = 0;
    int          failures = 0;
    int          expErr = 0;

    assign m_dat_i = {slvData[3], slvData[2], slvData[1], slvData[0]};

    always #5 clk = ~clk;

    user_wb_fabric #(
        .NUM_SLAVES     (NS),
        .SLV_BASE       ({32'h3000_3000, 32'h3000_0000, 32'h3000_1000, 32'h3000_0000}),
        .SLV_MASK       ({4{32'hFFFF_F000}}),
        .TIMEOUT_CYCLES (TO),
        .ERR_DATA       (ERR_VAL)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbs_cyc_i  (wbs_cyc),
        .wbs_stb_i  (wbs_stb),
        .wbs_we_i   (wbs_we),
        .wbs_sel_i  (wbs_sel),
        .wbs_adr_i  (wbs_adr),
        .wbs_dat_i  (wbs_dat),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .m_cyc_o    (m_cyc_o),
        .m_stb_o    (m_stb_o),
        .m_we_o     (m_we_o),
        .m_sel_o    (m_sel_o),
        .m_adr_o    (m_adr_o),
        .m_dat_o    (m_dat_o),
        .m_dat_i    (m_dat_i),
        .m_ack_i    (m_ack_i),
        .err_cnt_o  (err_cnt_o),
        .busy_o     (busy_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic cyc, input logic stb, input logic we,
                                 input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
        wbs_cyc = cyc;
        wbs_stb = stb;
        wbs_we  = we;
        wbs_sel = sel;
        wbs_adr = adr;
        wbs_dat = dat;
    endtask

    function automatic int refDecode(input logic [31:0] adr);
        for (int k = 0; k < NS; k++) begin
            if ((adr & maskTab[k]) == baseTab[k]) return k;
        end
        return -1;
    endfunction

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // One full upstream transaction; delay < 0 means the selected slave never acks,
    // otherwise it acks in strobe cycle delay+1. stray acks land on other ports only.
    task automatic runTxn(input string tag, input logic [31:0] adr, input logic [31:0] wdat,
                          input logic we, input logic [3:0] sel, input int delay, input logic [3:0] strayRaw);
        int          slot, expLat, lat, cycles, stbCyc, busyCyc;
        logic [3:0]  hot, stray;
        logic [31:0] expDat, gotDat, capAdr, capDat;
        logic        capWe, oneHotOk;
        logic [3:0]  capSel;

        slot = refDecode(adr);
        hot  = (slot < 0) ? 4'b0000 : 4'(1 << slot);
        stray = strayRaw & ~hot;
        if (slot < 0) begin
            expLat = 1;
            expDat = ERR_VAL;
            if (expErr < 16'hFFFF) expErr++;
        end else if (delay >= 0 && delay < TO) begin
            expLat = delay + 2;
            expDat = slvData[slot];
        end else begin
            expLat = TO + 1;
            expDat = ERR_VAL;
            if (expErr < 16'hFFFF) expErr++;
        end

        applyStimulus(1'b1, 1'b1, we, sel, adr, wdat);
        m_ack_i = stray;
        cycles = 0; lat = -1; stbCyc = 0; busyCyc = 0; oneHotOk = 1'b1;
        gotDat = '0; capAdr = '0; capDat = '0; capWe = 1'b0; capSel = '0;
        while (lat < 0 && cycles < 40) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (busy_o) busyCyc++;
            if (m_stb_o != 4'b0000) begin
                stbCyc++;
                if (m_stb_o !== hot || m_cyc_o !== m_stb_o) oneHotOk = 1'b0;
                if (stbCyc == 1) begin
                    capAdr = m_adr_o; capDat = m_dat_o; capWe = m_we_o; capSel = m_sel_o;
                end
            end
            if (wbs_ack_o) begin
                lat = cycles;
                gotDat = wbs_dat_o;
            end
            m_ack_i = stray | ((m_stb_o != 4'b0000 && delay >= 0 && stbCyc - 1 == delay) ? hot : 4'b0000);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        m_ack_i = '0;

        if (lat < 0) checkOutput({tag, ".ackBound"}, 32'd0, 32'd1);
        checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, ".rdata"}, gotDat, expDat);
        checkOutput({tag, ".errCnt"}, {16'h0, err_cnt_o}, 32'(expErr));
        checkOutput({tag, ".stbCycles"}, 32'(stbCyc), 32'((slot < 0) ? 0 : expLat - 1));
        checkOutput({tag, ".busyCycles"}, 32'(busyCyc), 32'((slot < 0) ? 0 : expLat - 1));
        checkOutput({tag, ".oneHot"}, {31'h0, oneHotOk}, 32'd1);
        if (slot >= 0) begin
            checkOutput({tag, ".mAdr"}, capAdr, adr);
            checkOutput({tag, ".mDat"}, capDat, wdat);
            checkOutput({tag, ".mWeSel"}, {27'h0, capWe, capSel}, {27'h0, we, sel});
        end
        idleCycles(1);
        checkOutput({tag, ".ackPulse"}, {31'h0, wbs_ack_o}, 32'd0);
    endtask

    initial begin
        logic        ackSeen;
        logic [31:0] radr;
        int          kind, dly;

        m_ack_i = '0;
        for (int k = 0; k < NS; k++) slvData[k] = 32'h0;

        $display("[TB] reset");
        idleCycles(3);
        checkOutput("reset.ctrl", {26'h0, wbs_ack_o, busy_o, m_stb_o}, 32'h0);
        checkOutput("reset.dat", wbs_dat_o, 32'h0);
        checkOutput("reset.err", {16'h0, err_cnt_o}, 32'h0);
        rst_n = 1'b1;
        idleCycles(1);

        $display("[TB] directed steps");
        slvData = '{32'h0000_AAA0, 32'h0000_AAA1, 32'h0000_AAA2, 32'hCAFE_0003};
        runTxn("wrSlave1", 32'h3000_1004, 32'h1234_5678, 1'b1, 4'hF, 0, 4'h0);
        runTxn("rdSlave3", 32'h3000_3010, 32'h0, 1'b0, 4'hF, 5, 4'h0);
        runTxn("unmapped", 32'h3100_0000, 32'h0, 1'b0, 4'hF, 0, 4'h0);
        runTxn("timeout", 32'h3000_0008, 32'h0, 1'b0, 4'h3, -1, 4'h0);
        runTxn("ackAtLimit", 32'h3000_000C, 32'h0, 1'b0, 4'hC, TO - 1, 4'h0);
        runTxn("overlap", 32'h3000_0020, 32'h5555_AAAA, 1'b1, 4'h1, 2, 4'b0100);

        $display("[TB] randomised transactions");
        for (int n = 0; n < 30; n++) begin
            for (int k = 0; k < NS; k++) slvData[k] = $urandom;
            kind = $urandom_range(0, 3);
            radr = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            case (kind)
                0:       radr = radr | 32'h3000_0000;
                1:       radr = radr | 32'h3000_1000;
                2:       radr = radr | 32'h3000_3000;
                default: radr = $urandom;
            endcase
            dly = $urandom_range(0, 10);
            runTxn("random", radr, $urandom, 1'($urandom), 4'($urandom), dly, 4'($urandom));
        end

        $display("[TB] upstream abort");
        applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 32'h3000_0040, 32'h0);
        idleCycles(3);
        checkOutput("abort.busy", {31'h0, busy_o}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        ackSeen = 1'b0;
        idleCycles(1);
        checkOutput("abort.stb", {28'h0, m_stb_o}, 32'h0);
        checkOutput("abort.idle", {31'h0, busy_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (wbs_ack_o) ackSeen = 1'b1;
            idleCycles(1);
        end
        checkOutput("abort.noAck", {31'h0, ackSeen}, 32'd0);
        checkOutput("abort.err", {16'h0, err_cnt_o}, 32'(expErr));

        $display("[TB] reset mid-transaction");
        applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, 32'h3000_1000, 32'h7777_7777);
        idleCycles(2);
        checkOutput("midRst.pre", {28'h0, m_stb_o}, 32'h2);
        rst_n = 1'b0;
        idleCycles(1);
        checkOutput("midRst.ctrl", {26'h0, wbs_ack_o, busy_o, m_cyc_o}, 32'h0);
        checkOutput("midRst.regs", {m_adr_o | m_dat_o | wbs_dat_o}, 32'h0);
        checkOutput("midRst.err", {16'h0, err_cnt_o}, 32'h0);
        expErr = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        idleCycles(1);
        rst_n = 1'b1;
        idleCycles(1);
        runTxn("postRst", 32'h3200_0000, 32'h0, 1'b0, 4'hF, 0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
